// File: rtl/segment_mem_access.sv
// MEM pipeline stage: issues loads/stores to data memory over req/ack, forwards non-memory ops.
// Latency: 1 cycle for non-memory ops; memory ops complete 1 cycle after dmem_ack (or abort).
// Backpressure: stall_out holds upstream while an access is outstanding; one access at a time.
module segment_mem_access #(
    parameter int DATA_W   = 22,
    parameter int ADDR_W   = 10,
    parameter int REG_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              MemToReg_in,
    input  logic              RegWrite_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              MemToReg_out,
    output logic              RegWrite_out,
    output logic              mem_timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_dmem_req;
    logic               r_dmem_we;
    logic [ADDR_W-1:0]  r_dmem_addr;
    logic [DATA_W-1:0]  r_dmem_wdata;
    logic [DATA_W-1:0]  r_lat_alu;
    logic [REG_W-1:0]   r_lat_rd;
    logic               r_lat_m2r;
    logic               r_lat_rw;
    logic               r_valid_out;
    logic [DATA_W-1:0]  r_mem_data_out;
    logic [DATA_W-1:0]  r_alu_result_out;
    logic [REG_W-1:0]   r_rd_out;
    logic               r_m2r_out;
    logic               r_rw_out;
    logic               r_timeout;

    logic               w_mem_op;
    logic               w_limit;

    assign w_mem_op = valid_in & (MemRead_in | MemWrite_in);
    assign w_limit  = (r_wait_cnt == CNT_W'(MAX_WAIT));

    // Upstream hold: issuing cycle, then every WAIT cycle until ack or abort releases it.
    always_comb begin
        stall_out = 1'b0;
        if (reset) begin
            if (r_state == S_IDLE) stall_out = w_mem_op;
            else                   stall_out = !(dmem_ack | w_limit);
        end
    end

    // Stage state machine: pass-through, issue, wait for ack, complete or abort.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_wait_cnt       <= '0;
            r_dmem_req       <= 1'b0;
            r_dmem_we        <= 1'b0;
            r_dmem_addr      <= '0;
            r_dmem_wdata     <= '0;
            r_lat_alu        <= '0;
            r_lat_rd         <= '0;
            r_lat_m2r        <= 1'b0;
            r_lat_rw         <= 1'b0;
            r_valid_out      <= 1'b0;
            r_mem_data_out   <= '0;
            r_alu_result_out <= '0;
            r_rd_out         <= '0;
            r_m2r_out        <= 1'b0;
            r_rw_out         <= 1'b0;
            r_timeout        <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_mem_op) begin
                // Store wins when both MemRead and MemWrite are set.
                r_state      <= S_WAIT;
                r_wait_cnt   <= '0;
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= MemWrite_in;
                r_dmem_addr  <= alu_result_in[ADDR_W-1:0];
                r_dmem_wdata <= write_data_in;
                r_lat_alu    <= alu_result_in;
                r_lat_rd     <= rd_in;
                r_lat_m2r    <= MemToReg_in;
                r_lat_rw     <= RegWrite_in;
                r_valid_out  <= 1'b0;
            end else begin
                r_valid_out    <= valid_in;
                r_mem_data_out <= '0;
                if (valid_in) begin
                    r_alu_result_out <= alu_result_in;
                    r_rd_out         <= rd_in;
                    r_m2r_out        <= MemToReg_in;
                    r_rw_out         <= RegWrite_in;
                end else begin
                    r_rw_out <= 1'b0;
                end
            end
        end else begin
            if (dmem_ack) begin
                // Ack beats the abort limit when both land in the same cycle.
                r_state          <= S_IDLE;
                r_wait_cnt       <= '0;
                r_dmem_req       <= 1'b0;
                r_valid_out      <= 1'b1;
                r_mem_data_out   <= r_dmem_we ? '0 : dmem_rdata;
                r_alu_result_out <= r_lat_alu;
                r_rd_out         <= r_lat_rd;
                r_m2r_out        <= r_lat_m2r;
                r_rw_out         <= r_lat_rw;
            end else if (w_limit) begin
                // Abort: retire the instruction with writeback suppressed and flag it.
                r_state          <= S_IDLE;
                r_wait_cnt       <= '0;
                r_dmem_req       <= 1'b0;
                r_valid_out      <= 1'b1;
                r_mem_data_out   <= '0;
                r_alu_result_out <= r_lat_alu;
                r_rd_out         <= r_lat_rd;
                r_m2r_out        <= r_lat_m2r;
                r_rw_out         <= 1'b0;
                r_timeout        <= 1'b1;
            end else begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

    assign dmem_req       = r_dmem_req;
    assign dmem_we        = r_dmem_we;
    assign dmem_addr      = r_dmem_addr;
    assign dmem_wdata     = r_dmem_wdata;
    assign valid_out      = r_valid_out;
    assign mem_data_out   = r_mem_data_out;
    assign alu_result_out = r_alu_result_out;
    assign rd_out         = r_rd_out;
    assign MemToReg_out   = r_m2r_out;
    assign RegWrite_out   = r_rw_out;
    assign mem_timeout    = r_timeout;

endmodule

// File: tb/tb_segment_mem_access.sv
// Bench for segment_mem_access: directed scenarios then random transactions.
// Expected outputs come from a transaction-level view of the stage behaviour.
// Memory side is driven directly by the bench with chosen ack delays.
module tb_segment_mem_access;

    localparam int DW = 22;
    localparam int AW = 10;
    localparam int RW = 4;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] alu_result_in;
    logic [DW-1:0] write_data_in;
    logic [RW-1:0] rd_in;
    logic          MemRead_in, MemWrite_in, MemToReg_in, RegWrite_in;
    logic          dmem_req, dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          dmem_ack;
    logic          stall_out, valid_out;
    logic [DW-1:0] mem_data_out, alu_result_out;
    logic [RW-1:0] rd_out;
    logic          MemToReg_out, RegWrite_out, mem_timeout;

    int checks = 0;
    int errors = 0;

    // Expected values of outputs that hold across bubbles.
    logic [DW-1:0] e_alu;
    logic [RW-1:0] e_rd;
    logic          e_m2r;
    logic          e_to;

    always #5 clk = ~clk;

    segment_mem_access #(.DATA_W(DW), .ADDR_W(AW), .REG_W(RW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .alu_result_in(alu_result_in), .write_data_in(write_data_in), .rd_in(rd_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_out(stall_out), .valid_out(valid_out), .mem_data_out(mem_data_out),
        .alu_result_out(alu_result_out), .rd_out(rd_out),
        .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out),
        .mem_timeout(mem_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] r22();
        logic [31:0] t;
        t = $urandom;
        return t[DW-1:0];
    endfunction

    function automatic logic [RW-1:0] r4();
        logic [31:0] t;
        t = $urandom;
        return t[RW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   dmem_req, 0);
        chk({tag, "_we"},    dmem_we, 0);
        chk({tag, "_addr"},  dmem_addr, 0);
        chk({tag, "_wdata"}, dmem_wdata, 0);
        chk({tag, "_stall"}, stall_out, 0);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_mdata"}, mem_data_out, 0);
        chk({tag, "_alu"},   alu_result_out, 0);
        chk({tag, "_rd"},    rd_out, 0);
        chk({tag, "_m2r"},   MemToReg_out, 0);
        chk({tag, "_rw"},    RegWrite_out, 0);
        chk({tag, "_to"},    mem_timeout, 0);
    endtask

    // Non-memory instruction (v=1) or bubble (v=0) through the stage.
    task automatic alu_op(input logic v, input logic [DW-1:0] a, input logic [RW-1:0] r,
                          input logic m2r, input logic rw);
        logic [31:0] t;
        t = $urandom;
        valid_in      = v;
        alu_result_in = a;
        write_data_in = r22();
        rd_in         = r;
        MemRead_in    = v ? 1'b0 : t[0];
        MemWrite_in   = v ? 1'b0 : t[1];
        MemToReg_in   = m2r;
        RegWrite_in   = rw;
        dmem_ack      = 1'b0;
        #1 chk("alu_stall", stall_out, 0);
        tick();
        if (v) begin
            e_alu = a;
            e_rd  = r;
            e_m2r = m2r;
        end
        chk("alu_valid", valid_out, v);
        chk("alu_result", alu_result_out, e_alu);
        chk("alu_rd", rd_out, e_rd);
        chk("alu_m2r", MemToReg_out, e_m2r);
        chk("alu_rw", RegWrite_out, v & rw);
        chk("alu_mdata", mem_data_out, 0);
        chk("alu_req", dmem_req, 0);
        chk("alu_to", mem_timeout, e_to);
    endtask

    // Memory instruction; ack arrives in WAIT cycle ack_at (0-based), never if ack_at<0.
    task automatic mem_op(input logic rd_f, input logic wr_f, input logic [DW-1:0] a,
                          input logic [DW-1:0] wd, input logic [RW-1:0] r,
                          input logic m2r, input logic rw, input int ack_at);
        logic          we;
        logic          acked;
        logic [DW-1:0] rdat;
        we    = wr_f;
        acked = 1'b0;
        rdat  = '0;
        valid_in      = 1'b1;
        alu_result_in = a;
        write_data_in = wd;
        rd_in         = r;
        MemRead_in    = rd_f;
        MemWrite_in   = wr_f;
        MemToReg_in   = m2r;
        RegWrite_in   = rw;
        dmem_ack      = 1'b0;
        #1 chk("mem_stall_issue", stall_out, 1);
        tick();
        for (int i = 0; i <= MW; i++) begin
            chk("wait_req", dmem_req, 1);
            chk("wait_we", dmem_we, we);
            chk("wait_addr", dmem_addr, a[AW-1:0]);
            chk("wait_wdata", dmem_wdata, wd);
            chk("wait_valid", valid_out, 0);
            if (i == ack_at) begin
                rdat       = r22();
                dmem_rdata = rdat;
                dmem_ack   = 1'b1;
                acked      = 1'b1;
            end else begin
                dmem_rdata = r22();
            end
            #1 chk("wait_stall", stall_out, (acked || i == MW) ? 0 : 1);
            tick();
            dmem_ack = 1'b0;
            if (acked) break;
        end
        e_alu = a;
        e_rd  = r;
        e_m2r = m2r;
        if (!acked) e_to = 1'b1;
        valid_in = 1'b0;
        chk("done_valid", valid_out, 1);
        chk("done_req", dmem_req, 0);
        chk("done_mdata", mem_data_out, (acked && !we) ? rdat : '0);
        chk("done_rw", RegWrite_out, acked ? rw : 1'b0);
        chk("done_alu", alu_result_out, e_alu);
        chk("done_rd", rd_out, e_rd);
        chk("done_m2r", MemToReg_out, e_m2r);
        chk("done_to", mem_timeout, e_to);
    endtask

    initial begin
        reset = 1'b0;
        valid_in = 1'b0; alu_result_in = '0; write_data_in = '0; rd_in = '0;
        MemRead_in = 1'b0; MemWrite_in = 1'b0; MemToReg_in = 1'b0; RegWrite_in = 1'b0;
        dmem_rdata = '0; dmem_ack = 1'b0;
        e_alu = '0; e_rd = '0; e_m2r = 1'b0; e_to = 1'b0;

        // Reset held for two cycles.
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b1;

        // Plain ALU op forwards with one cycle latency.
        alu_op(1'b1, 22'h123456, 4'd5, 1'b0, 1'b1);

        // Load, ack in third WAIT-stall cycle: stall high three cycles.
        mem_op(1'b1, 1'b0, 22'h000010, r22(), 4'd7, 1'b1, 1'b1, 2);

        // Store with immediate ack: single bubble.
        mem_op(1'b0, 1'b1, r22(), 22'h111111, 4'd3, 1'b0, 1'b0, 0);

        // Load that never gets acked: abort and sticky flag.
        mem_op(1'b1, 1'b0, r22(), r22(), 4'd9, 1'b1, 1'b1, -1);
        alu_op(1'b1, r22(), r4(), 1'b0, 1'b1);
        alu_op(1'b0, r22(), r4(), 1'b1, 1'b1);

        // Both flags set: store wins.
        mem_op(1'b1, 1'b1, r22(), r22(), r4(), 1'b1, 1'b1, 1);

        // Ack exactly at the abort limit wins.
        mem_op(1'b1, 1'b0, r22(), r22(), r4(), 1'b1, 1'b1, MW);

        // Random mix of bubbles, ALU ops, loads and stores.
        for (int n = 0; n < 40; n++) begin
            int k;
            int d;
            logic [31:0] t;
            k = $urandom_range(0, 9);
            d = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 5);
            t = $urandom;
            if (k < 2)      alu_op(1'b0, r22(), r4(), t[0], t[1]);
            else if (k < 5) alu_op(1'b1, r22(), r4(), t[0], t[1]);
            else if (k < 7) mem_op(1'b1, 1'b0, r22(), r22(), r4(), t[0], t[1], d);
            else if (k < 9) mem_op(1'b0, 1'b1, r22(), r22(), r4(), t[0], t[1], d);
            else            mem_op(1'b1, 1'b1, r22(), r22(), r4(), t[0], t[1], d);
        end

        // Reset in the middle of WAIT, then a late ack that must be ignored.
        valid_in = 1'b1; alu_result_in = r22(); write_data_in = r22(); rd_in = r4();
        MemRead_in = 1'b1; MemWrite_in = 1'b0; MemToReg_in = 1'b1; RegWrite_in = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_mid_req_before", dmem_req, 1);
        reset = 1'b0;
        valid_in = 1'b0; MemRead_in = 1'b0;
        tick();
        chk("rst_mid_req", dmem_req, 0);
        reset = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = r22();
        #1 chk("rst_ack_stall", stall_out, 0);
        tick();
        dmem_ack = 1'b0;
        chk_all_zero("late_ack");
        e_alu = '0; e_rd = '0; e_m2r = 1'b0; e_to = 1'b0;
        alu_op(1'b1, r22(), r4(), 1'b1, 1'b1);
        mem_op(1'b1, 1'b0, r22(), r22(), r4(), 1'b1, 1'b1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
